// File: rtl/id_fwd_stage_pkg.sv
// Shared decode constants for the ID stage: opcodes, function codes, ALU op/select encodings.
package id_fwd_stage_pkg;

  typedef logic [7:0] alu_op_t;
  typedef logic [2:0] alu_sel_t;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_SLTI    = 6'b001010;
  localparam logic [5:0] OP_SLTIU   = 6'b001011;
  localparam logic [5:0] OP_PREF    = 6'b110011;

  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SYNC = 6'b001111;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  localparam alu_op_t EXE_NOP_OP  = 8'b00000000;
  localparam alu_op_t EXE_AND_OP  = 8'b00100100;
  localparam alu_op_t EXE_OR_OP   = 8'b00100101;
  localparam alu_op_t EXE_XOR_OP  = 8'b00100110;
  localparam alu_op_t EXE_NOR_OP  = 8'b00100111;
  localparam alu_op_t EXE_SLL_OP  = 8'b01111100;
  localparam alu_op_t EXE_SRL_OP  = 8'b00000010;
  localparam alu_op_t EXE_SRA_OP  = 8'b00000011;
  localparam alu_op_t EXE_ADD_OP  = 8'b00100001;
  localparam alu_op_t EXE_SUB_OP  = 8'b00100011;
  localparam alu_op_t EXE_SLT_OP  = 8'b00101010;
  localparam alu_op_t EXE_SLTU_OP = 8'b00101011;

  localparam alu_sel_t EXE_RES_NOP   = 3'b000;
  localparam alu_sel_t EXE_RES_LOGIC = 3'b001;
  localparam alu_sel_t EXE_RES_SHIFT = 3'b010;
  localparam alu_sel_t EXE_RES_ARITH = 3'b100;

endpackage

// File: rtl/id_fwd_stage_if.sv
// ID/EX pipeline boundary bundle; the ID stage drives it (master), EX consumes it (slave).
// Carries ex_inst_invalid_o only when ID_INVALID_TRAP_EN is defined.
interface id_fwd_stage_if
  import id_fwd_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              ex_valid_o;
  logic [31:0]       ex_pc_o;
  alu_op_t           ex_aluop_o;
  alu_sel_t          ex_alusel_o;
  logic [DATA_W-1:0] ex_reg1_o;
  logic [DATA_W-1:0] ex_reg2_o;
  logic [REG_AW-1:0] ex_wd_o;
  logic              ex_wreg_o;
`ifdef ID_INVALID_TRAP_EN
  logic              ex_inst_invalid_o;
`endif

  modport master (
    output ex_valid_o, ex_pc_o, ex_aluop_o, ex_alusel_o,
    output ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o
`ifdef ID_INVALID_TRAP_EN
    , output ex_inst_invalid_o
`endif
  );

  modport slave (
    input ex_valid_o, ex_pc_o, ex_aluop_o, ex_alusel_o,
    input ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o
`ifdef ID_INVALID_TRAP_EN
    , input ex_inst_invalid_o
`endif
  );
endinterface

// File: rtl/id_fwd_mux.sv
// Per-port operand select: immediate, lowest-index matching bypass source, or regfile data.
module id_fwd_mux #(
  parameter int FWD_SRCS = 2,
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5
) (
  input  logic                       read_i,
  input  logic [REG_AW-1:0]          addr_i,
  input  logic [DATA_W-1:0]          rf_data_i,
  input  logic [DATA_W-1:0]          imm_i,
  input  logic [FWD_SRCS-1:0]        fwd_we_i,
  input  logic [FWD_SRCS*REG_AW-1:0] fwd_wd_i,
  input  logic [FWD_SRCS*DATA_W-1:0] fwd_wdata_i,
  input  logic [FWD_SRCS-1:0]        fwd_ld_i,
  output logic [DATA_W-1:0]          data_o,
  output logic                       hit_load_o
);
  logic hit;

  always_comb begin
    data_o     = read_i ? rf_data_i : imm_i;
    hit_load_o = 1'b0;
    hit        = 1'b0;
    // $0 is hard-wired, so a write to it must never shadow the regfile value
    if (read_i && (addr_i != '0)) begin
      for (int i = 0; i < FWD_SRCS; i++) begin
        if (!hit && fwd_we_i[i] && (fwd_wd_i[i*REG_AW +: REG_AW] == addr_i)) begin
          data_o     = fwd_wdata_i[i*DATA_W +: DATA_W];
          hit_load_o = fwd_ld_i[i];
          hit        = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/id_fwd_stage.sv
// MIPS decode with priority bypass, load-use interlock and registered ID/EX boundary.
// ID_INVALID_TRAP_EN: undecodable valid instructions pass to EX flagged instead of becoming bubbles.
module id_fwd_stage
  import id_fwd_stage_pkg::*;
#(
  parameter int FWD_SRCS = 2,
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       id_valid_i,
  input  logic [31:0]                pc_i,
  input  logic [31:0]                inst_i,
  input  logic [DATA_W-1:0]          reg1_data_i,
  input  logic [DATA_W-1:0]          reg2_data_i,
  output logic                       reg1_read_o,
  output logic                       reg2_read_o,
  output logic [REG_AW-1:0]          reg1_addr_o,
  output logic [REG_AW-1:0]          reg2_addr_o,
  input  logic [FWD_SRCS-1:0]        fwd_we_i,
  input  logic [FWD_SRCS*REG_AW-1:0] fwd_wd_i,
  input  logic [FWD_SRCS*DATA_W-1:0] fwd_wdata_i,
  input  logic [FWD_SRCS-1:0]        fwd_ld_i,
  input  logic                       stall_i,
  input  logic                       flush_i,
  output logic                       stall_req_o,
  id_fwd_stage_if.master             ex_if
);
  logic [5:0] op, funct;
  logic [4:0] sa;
  alu_op_t    aluop_c;
  alu_sel_t   alusel_c;
  logic       is_r3, is_shi, is_imm, is_nop, known_c, wreg_c, load_ok;
  logic [REG_AW-1:0] wd_c;
  logic [DATA_W-1:0] imm_c, opnd1, opnd2;
  logic       hit1_ld, hit2_ld;

  logic              valid_q, valid_d, wreg_q, wreg_d, inv_q, inv_d;
  logic [31:0]       pc_q, pc_d;
  alu_op_t           aluop_q, aluop_d;
  alu_sel_t          alusel_q, alusel_d;
  logic [DATA_W-1:0] reg1_q, reg1_d, reg2_q, reg2_d;
  logic [REG_AW-1:0] wd_q, wd_d;

  assign op          = inst_i[31:26];
  assign funct       = inst_i[5:0];
  assign sa          = inst_i[10:6];
  assign reg1_addr_o = REG_AW'(inst_i[25:21]);
  assign reg2_addr_o = REG_AW'(inst_i[20:16]);

  always_comb begin
    aluop_c  = EXE_NOP_OP;
    alusel_c = EXE_RES_NOP;
    imm_c    = '0;
    is_r3    = 1'b0;
    is_shi   = 1'b0;
    is_imm   = 1'b0;
    is_nop   = 1'b0;
    if (id_valid_i) begin
      case (op)
        OP_SPECIAL: begin
          if (sa == 5'd0) begin
            is_r3 = 1'b1;
            case (funct)
              FN_AND:  begin aluop_c = EXE_AND_OP;  alusel_c = EXE_RES_LOGIC; end
              FN_OR:   begin aluop_c = EXE_OR_OP;   alusel_c = EXE_RES_LOGIC; end
              FN_XOR:  begin aluop_c = EXE_XOR_OP;  alusel_c = EXE_RES_LOGIC; end
              FN_NOR:  begin aluop_c = EXE_NOR_OP;  alusel_c = EXE_RES_LOGIC; end
              FN_SLLV: begin aluop_c = EXE_SLL_OP;  alusel_c = EXE_RES_SHIFT; end
              FN_SRLV: begin aluop_c = EXE_SRL_OP;  alusel_c = EXE_RES_SHIFT; end
              FN_SRAV: begin aluop_c = EXE_SRA_OP;  alusel_c = EXE_RES_SHIFT; end
              FN_ADDU: begin aluop_c = EXE_ADD_OP;  alusel_c = EXE_RES_ARITH; end
              FN_SUBU: begin aluop_c = EXE_SUB_OP;  alusel_c = EXE_RES_ARITH; end
              FN_SLT:  begin aluop_c = EXE_SLT_OP;  alusel_c = EXE_RES_ARITH; end
              FN_SLTU: begin aluop_c = EXE_SLTU_OP; alusel_c = EXE_RES_ARITH; end
              FN_SYNC: begin is_r3 = 1'b0; is_nop = 1'b1; end
              default: is_r3 = 1'b0;
            endcase
          end
          // shift-immediate forms require rs == 0
          if (inst_i[25:21] == 5'd0) begin
            case (funct)
              FN_SLL: begin is_shi = 1'b1; aluop_c = EXE_SLL_OP; alusel_c = EXE_RES_SHIFT; end
              FN_SRL: begin is_shi = 1'b1; aluop_c = EXE_SRL_OP; alusel_c = EXE_RES_SHIFT; end
              FN_SRA: begin is_shi = 1'b1; aluop_c = EXE_SRA_OP; alusel_c = EXE_RES_SHIFT; end
              default: ;
            endcase
            if (is_shi) imm_c = DATA_W'(sa);
          end
        end
        OP_ORI:   begin is_imm = 1'b1; aluop_c = EXE_OR_OP;  alusel_c = EXE_RES_LOGIC;
                        imm_c = DATA_W'(inst_i[15:0]); end
        OP_ANDI:  begin is_imm = 1'b1; aluop_c = EXE_AND_OP; alusel_c = EXE_RES_LOGIC;
                        imm_c = DATA_W'(inst_i[15:0]); end
        OP_XORI:  begin is_imm = 1'b1; aluop_c = EXE_XOR_OP; alusel_c = EXE_RES_LOGIC;
                        imm_c = DATA_W'(inst_i[15:0]); end
        OP_LUI:   begin is_imm = 1'b1; aluop_c = EXE_OR_OP;  alusel_c = EXE_RES_LOGIC;
                        imm_c = {inst_i[15:0], {(DATA_W-16){1'b0}}}; end
        OP_ADDIU: begin is_imm = 1'b1; aluop_c = EXE_ADD_OP; alusel_c = EXE_RES_ARITH;
                        imm_c = {{(DATA_W-16){inst_i[15]}}, inst_i[15:0]}; end
        OP_SLTI:  begin is_imm = 1'b1; aluop_c = EXE_SLT_OP; alusel_c = EXE_RES_ARITH;
                        imm_c = {{(DATA_W-16){inst_i[15]}}, inst_i[15:0]}; end
        OP_SLTIU: begin is_imm = 1'b1; aluop_c = EXE_SLTU_OP; alusel_c = EXE_RES_ARITH;
                        imm_c = {{(DATA_W-16){inst_i[15]}}, inst_i[15:0]}; end
        OP_PREF:  is_nop = 1'b1;
        default:  ;
      endcase
    end
  end

  assign known_c     = is_r3 | is_shi | is_imm | is_nop;
  assign wreg_c      = is_r3 | is_shi | is_imm;
  assign wd_c        = is_imm ? REG_AW'(inst_i[20:16]) : (wreg_c ? REG_AW'(inst_i[15:11]) : '0);
  assign reg1_read_o = is_r3 | is_imm;
  assign reg2_read_o = is_r3 | is_shi;

  id_fwd_mux #(.FWD_SRCS(FWD_SRCS), .DATA_W(DATA_W), .REG_AW(REG_AW)) u_mux1 (
    .read_i(reg1_read_o), .addr_i(reg1_addr_o), .rf_data_i(reg1_data_i), .imm_i(imm_c),
    .fwd_we_i(fwd_we_i), .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i), .fwd_ld_i(fwd_ld_i),
    .data_o(opnd1), .hit_load_o(hit1_ld));

  id_fwd_mux #(.FWD_SRCS(FWD_SRCS), .DATA_W(DATA_W), .REG_AW(REG_AW)) u_mux2 (
    .read_i(reg2_read_o), .addr_i(reg2_addr_o), .rf_data_i(reg2_data_i), .imm_i(imm_c),
    .fwd_we_i(fwd_we_i), .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i), .fwd_ld_i(fwd_ld_i),
    .data_o(opnd2), .hit_load_o(hit2_ld));

  assign stall_req_o = hit1_ld | hit2_ld;

`ifdef ID_INVALID_TRAP_EN
  assign load_ok = id_valid_i;
`else
  assign load_ok = known_c;
`endif

  always_comb begin
    valid_d  = valid_q;
    pc_d     = pc_q;
    aluop_d  = aluop_q;
    alusel_d = alusel_q;
    reg1_d   = reg1_q;
    reg2_d   = reg2_q;
    wd_d     = wd_q;
    wreg_d   = wreg_q;
    inv_d    = inv_q;
    if (flush_i || (!stall_i && (stall_req_o || !load_ok))) begin
      valid_d  = 1'b0;
      pc_d     = '0;
      aluop_d  = EXE_NOP_OP;
      alusel_d = EXE_RES_NOP;
      reg1_d   = '0;
      reg2_d   = '0;
      wd_d     = '0;
      wreg_d   = 1'b0;
      inv_d    = 1'b0;
    end else if (!stall_i) begin
      valid_d  = 1'b1;
      pc_d     = pc_i;
      aluop_d  = aluop_c;
      alusel_d = alusel_c;
      reg1_d   = opnd1;
      reg2_d   = opnd2;
      wd_d     = wd_c;
      wreg_d   = wreg_c;
      inv_d    = !known_c;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      aluop_q  <= EXE_NOP_OP;
      alusel_q <= EXE_RES_NOP;
      reg1_q   <= '0;
      reg2_q   <= '0;
      wd_q     <= '0;
      wreg_q   <= 1'b0;
      inv_q    <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      aluop_q  <= aluop_d;
      alusel_q <= alusel_d;
      reg1_q   <= reg1_d;
      reg2_q   <= reg2_d;
      wd_q     <= wd_d;
      wreg_q   <= wreg_d;
      inv_q    <= inv_d;
    end
  end

  assign ex_if.ex_valid_o  = valid_q;
  assign ex_if.ex_pc_o     = pc_q;
  assign ex_if.ex_aluop_o  = aluop_q;
  assign ex_if.ex_alusel_o = alusel_q;
  assign ex_if.ex_reg1_o   = reg1_q;
  assign ex_if.ex_reg2_o   = reg2_q;
  assign ex_if.ex_wd_o     = wd_q;
  assign ex_if.ex_wreg_o   = wreg_q;
`ifdef ID_INVALID_TRAP_EN
  assign ex_if.ex_inst_invalid_o = inv_q;
`else
  logic unused_inv;
  assign unused_inv = inv_q;
`endif
endmodule

// File: tb/tb_id_fwd_stage.sv
// Directed bench for id_fwd_stage with three bypass sources; expectations are hand-computed.
module tb_id_fwd_stage;
  import id_fwd_stage_pkg::*;

  localparam int NS = 3;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          id_valid_i = 1'b0;
  logic [31:0]   pc_i = '0, inst_i = '0;
  logic [DW-1:0] reg1_data_i = '0, reg2_data_i = '0;
  logic          reg1_read_o, reg2_read_o;
  logic [AW-1:0] reg1_addr_o, reg2_addr_o;
  logic [NS-1:0]    fwd_we_i = '0, fwd_ld_i = '0;
  logic [NS*AW-1:0] fwd_wd_i = '0;
  logic [NS*DW-1:0] fwd_wdata_i = '0;
  logic          stall_i = 1'b0, flush_i = 1'b0;
  logic          stall_req_o;
  int            total = 0;
  int            bad = 0;

  id_fwd_stage_if #(.DATA_W(DW), .REG_AW(AW)) ex_if ();

  id_fwd_stage #(.FWD_SRCS(NS), .DATA_W(DW), .REG_AW(AW)) dut (
    .clk(clk), .rst(rst), .id_valid_i(id_valid_i), .pc_i(pc_i), .inst_i(inst_i),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .fwd_we_i(fwd_we_i), .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i), .fwd_ld_i(fwd_ld_i),
    .stall_i(stall_i), .flush_i(flush_i), .stall_req_o(stall_req_o), .ex_if(ex_if));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    chk("rst_valid", 32'(ex_if.ex_valid_o), 32'd0);
    chk("rst_aluop", 32'(ex_if.ex_aluop_o), 32'(EXE_NOP_OP));
    chk("rst_wreg", 32'(ex_if.ex_wreg_o), 32'd0);
    rst = 1'b1;

    // ORI $1,$0,0x1234
    id_valid_i = 1'b1; pc_i = 32'h100; inst_i = 32'h34011234;
    #1;
    chk("ori_rd1", 32'(reg1_read_o), 32'd1);
    chk("ori_rd2", 32'(reg2_read_o), 32'd0);
    chk("ori_addr2", 32'(reg2_addr_o), 32'd1);
    tick();
    chk("ori_reg1", ex_if.ex_reg1_o, 32'h0);
    chk("ori_reg2", ex_if.ex_reg2_o, 32'h00001234);
    chk("ori_wd", 32'(ex_if.ex_wd_o), 32'd1);
    chk("ori_wreg", 32'(ex_if.ex_wreg_o), 32'd1);
    chk("ori_valid", 32'(ex_if.ex_valid_o), 32'd1);
    chk("ori_pc", ex_if.ex_pc_o, 32'h100);
    chk("ori_sel", 32'(ex_if.ex_alusel_o), 32'(EXE_RES_LOGIC));

    // OR $3,$1,$2 with src0 $1, src1 $1, src2 $2
    pc_i = 32'h104; inst_i = 32'h00221825;
    fwd_we_i = 3'b111; fwd_ld_i = 3'b000;
    fwd_wd_i = {5'd2, 5'd1, 5'd1};
    fwd_wdata_i = {32'h00000F0F, 32'h00005555, 32'hAAAA0000};
    tick();
    chk("or_reg1", ex_if.ex_reg1_o, 32'hAAAA0000);
    chk("or_reg2", ex_if.ex_reg2_o, 32'h00000F0F);
    chk("or_wd", 32'(ex_if.ex_wd_o), 32'd3);
    chk("or_op", 32'(ex_if.ex_aluop_o), 32'(EXE_OR_OP));

    // ADDU $4,$0,$5 with src0 writing $0
    inst_i = 32'h00052021; reg2_data_i = 32'h77;
    fwd_we_i = 3'b001; fwd_wd_i = {5'd0, 5'd0, 5'd0}; fwd_wdata_i = {32'h0, 32'h0, 32'h0000DEAD};
    tick();
    chk("addu_r0", ex_if.ex_reg1_o, 32'h0);
    chk("addu_reg2", ex_if.ex_reg2_o, 32'h77);
    chk("addu_op", 32'(ex_if.ex_aluop_o), 32'(EXE_ADD_OP));
    chk("addu_sel", 32'(ex_if.ex_alusel_o), 32'(EXE_RES_ARITH));

    // ADDIU $6,$7,0xFFFF then ANDI $6,$7,0xFFFF
    fwd_we_i = '0; reg1_data_i = 32'h10; inst_i = 32'h24E6FFFF;
    tick();
    chk("addiu_sext", ex_if.ex_reg2_o, 32'hFFFFFFFF);
    chk("addiu_reg1", ex_if.ex_reg1_o, 32'h10);
    chk("addiu_wd", 32'(ex_if.ex_wd_o), 32'd6);
    inst_i = 32'h30E6FFFF;
    tick();
    chk("andi_zext", ex_if.ex_reg2_o, 32'h0000FFFF);
    chk("andi_op", 32'(ex_if.ex_aluop_o), 32'(EXE_AND_OP));

    // SLL $2,$3,4
    inst_i = 32'h00031100; reg2_data_i = 32'h5;
    #1;
    chk("sll_rd1", 32'(reg1_read_o), 32'd0);
    tick();
    chk("sll_sa", ex_if.ex_reg1_o, 32'd4);
    chk("sll_reg2", ex_if.ex_reg2_o, 32'h5);
    chk("sll_sel", 32'(ex_if.ex_alusel_o), 32'(EXE_RES_SHIFT));

    // load-use on $1 from src0
    inst_i = 32'h00221825; pc_i = 32'h200; reg2_data_i = 32'h22;
    fwd_we_i = 3'b001; fwd_ld_i = 3'b001; fwd_wd_i = {5'd0, 5'd0, 5'd1};
    fwd_wdata_i = {32'h0, 32'h0, 32'hBAD0BAD0};
    #1;
    chk("lu_stall", 32'(stall_req_o), 32'd1);
    tick();
    chk("lu_bubble", 32'(ex_if.ex_valid_o), 32'd0);
    chk("lu_wreg", 32'(ex_if.ex_wreg_o), 32'd0);
    fwd_we_i = 3'b010; fwd_ld_i = 3'b000; fwd_wd_i = {5'd0, 5'd1, 5'd0};
    fwd_wdata_i = {32'h0, 32'h12345678, 32'h0};
    #1;
    chk("lu_release", 32'(stall_req_o), 32'd0);
    tick();
    chk("lu_reg1", ex_if.ex_reg1_o, 32'h12345678);
    chk("lu_reg2", ex_if.ex_reg2_o, 32'h22);
    chk("lu_valid", 32'(ex_if.ex_valid_o), 32'd1);

    // downstream stall holds for two cycles despite a new instruction
    stall_i = 1'b1; inst_i = 32'h24E6FFFF; pc_i = 32'h300; fwd_we_i = '0;
    tick();
    chk("stall1_reg1", ex_if.ex_reg1_o, 32'h12345678);
    tick();
    chk("stall2_wd", 32'(ex_if.ex_wd_o), 32'd3);
    chk("stall2_pc", ex_if.ex_pc_o, 32'h200);

    // stall with hazard keeps requesting
    inst_i = 32'h00221825; fwd_we_i = 3'b001; fwd_ld_i = 3'b001; fwd_wd_i = {5'd0, 5'd0, 5'd1};
    tick();
    chk("stall_haz_req", 32'(stall_req_o), 32'd1);
    chk("stall_haz_hold", 32'(ex_if.ex_valid_o), 32'd1);

    // flush wins over stall
    flush_i = 1'b1;
    tick();
    chk("flush_valid", 32'(ex_if.ex_valid_o), 32'd0);
    chk("flush_pc", ex_if.ex_pc_o, 32'h0);
    flush_i = 1'b0; stall_i = 1'b0; fwd_we_i = '0; fwd_ld_i = '0;

    // SYNC: valid, no writeback
    inst_i = 32'h0000000F;
    tick();
    chk("sync_valid", 32'(ex_if.ex_valid_o), 32'd1);
    chk("sync_wreg", 32'(ex_if.ex_wreg_o), 32'd0);

    // undecodable opcode
    inst_i = 32'hFC000000;
    tick();
`ifdef ID_INVALID_TRAP_EN
    chk("inv_valid", 32'(ex_if.ex_valid_o), 32'd1);
    chk("inv_flag", 32'(ex_if.ex_inst_invalid_o), 32'd1);
`else
    chk("inv_bubble", 32'(ex_if.ex_valid_o), 32'd0);
`endif
    chk("inv_wreg", 32'(ex_if.ex_wreg_o), 32'd0);

    // id_valid_i low: no reads, bubble
    id_valid_i = 1'b0; inst_i = 32'h00221825;
    #1;
    chk("idle_rd1", 32'(reg1_read_o), 32'd0);
    tick();
    chk("idle_valid", 32'(ex_if.ex_valid_o), 32'd0);

    // async reset mid-cycle
    id_valid_i = 1'b1; inst_i = 32'h34011234; reg1_data_i = 32'h0;
    tick();
    chk("pre_rst_valid", 32'(ex_if.ex_valid_o), 32'd1);
    #3 rst = 1'b0;
    #1;
    chk("async_valid", 32'(ex_if.ex_valid_o), 32'd0);
    chk("async_reg2", ex_if.ex_reg2_o, 32'h0);
    #1 rst = 1'b1;
    tick();
    chk("post_rst_reg2", ex_if.ex_reg2_o, 32'h00001234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
